mc_main_control: RTL and testbench

- Multicycle MIPS main control FSM. Sits directly upstream of alu_control.
- Decodes the IR opcode and produces ALUOp[1:0] for alu_control, plus all datapath mux, enable and memory strobes.
- Moore FSM with a memory-ready handshake. Supports R-type, lw, sw, beq and j; addi is optional.

---
 rtl/mc_main_control.sv | 176 +++++++++++++++++
 tb/tb_mc_main_control.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: decodes the IR opcode into datapath strobes and ALUOp.
// Optional addi support is built in when MC_CTRL_ADDI_EN is defined.
module mc_main_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam int unsigned OP_W = 6;
  localparam int unsigned ST_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
`endif

  localparam logic [ST_W-1:0] S_RST     = 4'd0;
  localparam logic [ST_W-1:0] S_FETCH   = 4'd1;
  localparam logic [ST_W-1:0] S_DECODE  = 4'd2;
  localparam logic [ST_W-1:0] S_MEMADDR = 4'd3;
  localparam logic [ST_W-1:0] S_MEMRD   = 4'd4;
  localparam logic [ST_W-1:0] S_MEMWB   = 4'd5;
  localparam logic [ST_W-1:0] S_MEMWR   = 4'd6;
  localparam logic [ST_W-1:0] S_EXEC    = 4'd7;
  localparam logic [ST_W-1:0] S_RCOMP   = 4'd8;
  localparam logic [ST_W-1:0] S_BRANCH  = 4'd9;
  localparam logic [ST_W-1:0] S_JUMP    = 4'd10;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [ST_W-1:0] S_ADDI_EX = 4'd11;
  localparam logic [ST_W-1:0] S_ADDI_WB = 4'd12;
`endif

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;

  assign state = state_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // Next-state logic; RST, single-cycle terminals and unused codes all fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADDR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    state_d = S_RCOMP;
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EX: state_d = S_ADDI_WB;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore outputs; only the FETCH IR/PC load is gated by mem_ready
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: illegal_op = 1'b0;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:                              illegal_op = 1'b0;
`endif
          default:                              illegal_op = 1'b1;
        endcase
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RCOMP: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: directed instruction flows, reset abort and random
// instruction streams checked against a per-instruction state-path model.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal;
  } ctl_t;

  typedef int path_t[$];

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t observed();
    ctl_t c;
    c = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
         RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
    return c;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    bit ok;
    ok = (op == 6'h00) || (op == 6'h23) || (op == 6'h2b) || (op == 6'h04) || (op == 6'h02);
`ifdef MC_CTRL_ADDI_EN
    ok = ok || (op == 6'h08);
`endif
    return ok;
  endfunction

  // Sequence of states an instruction visits, excluding memory stalls
  function automatic path_t path_of(input logic [5:0] op);
    path_t p;
    p = '{1, 2};
    case (op)
      6'h23: p = '{1, 2, 3, 4, 5};
      6'h2b: p = '{1, 2, 3, 6};
      6'h00: p = '{1, 2, 7, 8};
      6'h04: p = '{1, 2, 9};
      6'h02: p = '{1, 2, 10};
`ifdef MC_CTRL_ADDI_EN
      6'h08: p = '{1, 2, 11, 12};
`endif
      default: p = '{1, 2};
    endcase
    return p;
  endfunction

  // Latency figures quoted for each instruction class with memory always ready
  function automatic int spec_latency(input logic [5:0] op);
    if (!is_legal(op)) return 2;
    case (op)
      6'h23:        return 5;
      6'h2b, 6'h00: return 4;
      6'h08:        return 4;
      default:      return 3;
    endcase
  endfunction

  function automatic ctl_t expect_ctl(input int st, input bit mr, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (st)
      1:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
      2:  begin c.alusrcb = 2'b11; c.illegal = !is_legal(op); end
      3:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      4:  begin c.memread = 1; c.iord = 1; end
      5:  begin c.regwrite = 1; c.memtoreg = 1; end
      6:  begin c.memwrite = 1; c.iord = 1; end
      7:  begin c.alusrca = 1; c.aluop = 2'b10; end
      8:  begin c.regwrite = 1; c.regdst = 1; end
      9:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcwritecond = 1; c.pcsource = 2'b01; end
      10: begin c.pcwrite = 1; c.pcsource = 2'b10; end
`ifdef MC_CTRL_ADDI_EN
      11: begin c.alusrca = 1; c.alusrcb = 2'b10; end
      12: begin c.regwrite = 1; end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  // Runs one instruction starting at a negedge with the DUT in FETCH.
  // fstall/mstall give the number of not-ready cycles in FETCH / memory states;
  // rnd replaces them with random readiness (capped so it always completes).
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall, input bit rnd);
    path_t q;
    int    p, cycles, in_state, stalls, need, st;
    bit    mr, waits;
    q = path_of(op);
    p = 0; cycles = 0; in_state = 0; stalls = 0;
    while (p < q.size()) begin
      st = q[p];
      waits = (st == 1) || (st == 4) || (st == 6);
      need = (st == 1) ? fstall : mstall;
      if (!waits)  mr = 1'($urandom_range(0, 1));
      else if (rnd) mr = (in_state >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      else         mr = (in_state >= need);
      opcode    = (st == 1) ? 6'($urandom) : op;
      mem_ready = mr;
      #1;
      check($sformatf("state op=%h c%0d", op, cycles), 32'(state), 32'(st));
      check($sformatf("ctl op=%h st=%0d", op, st), 32'(observed()), 32'(expect_ctl(st, mr, op)));
      check("mutex", 32'((MemRead & MemWrite) | (RegWrite & IRWrite)), 32'd0);
      cycles++;
      if (waits && !mr) begin in_state++; stalls++; end
      else begin p++; in_state = 0; end
      if (cycles > 100) begin
        check("timeout", 32'(cycles), 32'd0);
        return;
      end
      @(negedge clk);
    end
    check($sformatf("latency op=%h", op), 32'(cycles), 32'(spec_latency(op) + stalls));
  endtask

  initial begin
    logic [5:0] pick [7];
    logic [5:0] op;
    pick[0] = 6'h00; pick[1] = 6'h23; pick[2] = 6'h2b; pick[3] = 6'h04;
    pick[4] = 6'h02; pick[5] = 6'h08; pick[6] = 6'h3f;

    // Reset: everything zero, held through a clock edge
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00;
    #1;
    check("rst state", 32'(state), 32'd0);
    check("rst ctl", 32'(observed()), 32'd0);
    @(negedge clk);
    check("rst hold", 32'(state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst release", 32'(state), 32'd1);

    // Directed flows
    run_instr(6'h00, 0, 0, 1'b0);
    run_instr(6'h23, 0, 2, 1'b0);
    run_instr(6'h2b, 0, 0, 1'b0);
    run_instr(6'h04, 0, 0, 1'b0);
    run_instr(6'h02, 0, 0, 1'b0);
    run_instr(6'h00, 3, 0, 1'b0);
    run_instr(6'h2b, 1, 2, 1'b0);
    run_instr(6'h3f, 0, 0, 1'b0);
    run_instr(6'h08, 0, 0, 1'b0);

    // Asynchronous reset in the middle of EXEC
    opcode = 6'h00; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre-abort state", 32'(state), 32'd7);
    #1 rst_n = 1'b0;
    #1;
    check("abort state", 32'(state), 32'd0);
    check("abort ctl", 32'(observed()), 32'd0);
    @(negedge clk);
    check("abort hold", 32'(state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("abort fetch", 32'(state), 32'd1);
    check("abort fetch ctl", 32'(observed()), 32'(expect_ctl(1, 1'b1, 6'h00)));

    // Random instruction stream
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = pick[$urandom_range(0, 6)];
      run_instr(op, 0, 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
